dff_delay_line: RTL and testbench
=================================

DFF_DELAY_LINE -- requirements
Module: dff_delay_line

Interface
REQ-001 SHALL provide parameter WIDTH, default 1, data width in bits (1..64).
REQ-002 SHALL provide parameter DEPTH, default 16, number of register stages (1..256).
REQ-003 SHALL provide parameter INIT, default all-zero (WIDTH bits), power-up and reset value of every stage.
REQ-004 SHALL provide parameter NEG_EDGE, default 1'b0; 0 = stages sample on rising CLK, 1 = stages sample on falling CLK.
REQ-005 SHALL derive local constant AW = max(1, clog2(DEPTH)).
REQ-006 SHALL have port CLK  input  1  sole clock; active edge per NEG_EDGE.
REQ-007 SHALL have port RESETN  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port CE  input  1  clock enable; shift occurs only when high.
REQ-009 SHALL have port SCLR  input  1  synchronous clear, active-high.
REQ-010 SHALL have port D  input  WIDTH  data into stage 0.
REQ-011 SHALL have port TAP  input  AW  output stage select.
REQ-012 SHALL have port Q  output  WIDTH  contents of selected stage.
REQ-013 SHALL have port FILL  output  AW+1  count of valid stages, saturating at DEPTH.
REQ-014 SHALL have port PRIMED  output  1  high when the selected stage holds shifted-in data.

Function
REQ-015 SHALL, on an active edge with SCLR=0 and CE=1, load stage[0]<=D and stage[i]<=stage[i-1] for i=1..DEPTH-1.
REQ-016 SHALL hold all stages and FILL on an active edge with CE=0 and SCLR=0.
REQ-017 SHALL drive Q combinationally from stage[TAP]; a sample on D appears on Q after TAP+1 enabled edges.
REQ-018 SHALL clamp TAP >= DEPTH to DEPTH-1 for Q and PRIMED; no X propagation.
REQ-019 SHALL increment FILL by 1 on each enabled shift while FILL < DEPTH, then hold at DEPTH (no wrap).
REQ-020 SHALL drive PRIMED = (FILL > clamped TAP), combinationally, so a TAP change updates it in the same cycle.
REQ-021 SHALL, on an active edge with SCLR=1, set every stage to INIT and FILL to 0 regardless of CE; SCLR has priority over shift.
REQ-022 SHALL, for DEPTH=1, behave as a single enabled register with TAP ignored and FILL in {0,1}.
REQ-023 SHALL leave D sampling free of any combinational path to Q other than through stage registers.

Reset
REQ-024 SHALL, while RESETN=0, force every stage to INIT and FILL to 0 immediately, independent of CLK and CE.
REQ-025 SHALL resume shifting on the first active edge after RESETN deasserts; reset mid-fill discards all prior data.
REQ-026 SHALL give every stage the value INIT and FILL the value 0 at simulation start (initial values), before any reset.
REQ-027 SHALL present Q=INIT, FILL=0, PRIMED=0 in reset.

Structure
REQ-028 SHALL place the clog2 helper function and the edge-select constants (RISE=0, FALL=1) in shared package gowin_prim_pkg.
REQ-029 SHALL implement the saturating fill counter as one sub-module, dff_fill_ctr (inputs CLK, RESETN, INC, CLR; output count).
REQ-030 SHALL select the clock edge with a single generate branch on NEG_EDGE, not a muxed clock.
REQ-031 SHALL compile lint-clean under Verilator and standard simulators, with no vendor-specific constructs.

Verification (WIDTH=8, DEPTH=4, INIT=8'h00 unless stated)
REQ-032 SHALL test: reset, CE=1, D=8'h11,22,33,44 on 4 rising edges, TAP=3 -> Q=8'h11 after edge 4, FILL=4, PRIMED=1; after edge 3 PRIMED=0.
REQ-033 SHALL test: CE toggled 1,0,1 with D=8'hA5,8'hFF,8'h5A, TAP=1 -> Q=8'hA5 after third edge, FILL=2; 8'hFF never stored.
REQ-034 SHALL test: full line, then SCLR=1 with CE=1 and D=8'h77 for one edge -> all stages 8'h00, FILL=0, PRIMED=0; 8'h77 not stored.
REQ-035 SHALL test: RESETN pulled low between edges after 2 shifts -> Q=INIT and FILL=0 before the next edge; run with INIT=8'hC3 -> Q=8'hC3.
REQ-036 SHALL test: NEG_EDGE=1, D=8'h3C presented -> stage 0 updates on falling CLK only, unchanged on rising CLK.
REQ-037 SHALL test: DEPTH=5 (AW=3), TAP=7 -> Q equals stage[4], PRIMED set only when FILL=5; DEPTH=1 runs 10 shifts -> FILL saturates at 1.

Source files
------------

// File: rtl/gowin_prim_pkg.sv
// Shared primitive helpers: clock-edge select
// constants and a constant-safe clog2.
package gowin_prim_pkg;

    localparam bit RISE = 1'b0;
    localparam bit FALL = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int addr_w(input int depth);
        int c;
        c = clog2(depth);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/dff_fill_ctr.sv
// Saturating fill counter for the delay line.
// Counts enabled shifts up to DEPTH, clears on CLR.
module dff_fill_ctr
    import gowin_prim_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter bit NEG_EDGE = RISE,
    localparam int CW      = addr_w(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RESETN,
    input  logic          INC,
    input  logic          CLR,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] MAXC = CW'(DEPTH);

    logic [CW-1:0] cnt = '0;
    logic [CW-1:0] cnt_nxt;

    // Clear wins, otherwise step until saturated.
    always_comb begin
        cnt_nxt = cnt;
        if (CLR) begin
            cnt_nxt = '0;
        end else if (INC && (cnt < MAXC)) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    generate
        if (NEG_EDGE == FALL) begin : g_fall
            // Counter register on falling clock.
            always_ff @(negedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt_nxt;
                end
            end
        end else begin : g_rise
            // Counter register on rising clock.
            always_ff @(posedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt_nxt;
                end
            end
        end
    endgenerate

    assign count = cnt;

endmodule

// File: rtl/dff_delay_line.sv
// Tapped shift-register delay line with clock
// enable, sync clear and a fill/primed indicator.
module dff_delay_line
    import gowin_prim_pkg::*;
#(
    parameter int             WIDTH    = 1,
    parameter int             DEPTH    = 16,
    parameter logic [WIDTH-1:0] INIT   = '0,
    parameter bit             NEG_EDGE = RISE,
    localparam int            AW       = addr_w(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             CE,
    input  logic             SCLR,
    input  logic [WIDTH-1:0] D,
    input  logic [AW-1:0]    TAP,
    output logic [WIDTH-1:0] Q,
    output logic [AW:0]      FILL,
    output logic             PRIMED
);

    typedef logic [DEPTH-1:0][WIDTH-1:0] line_t;

    localparam line_t LINE_INIT = {DEPTH{INIT}};

    line_t stage = LINE_INIT;
    line_t stage_nxt;

    logic [AW-1:0] tap_c;
    logic          shift_en;

    assign shift_en = CE & ~SCLR;

    // Next line contents: clear, shift or hold.
    always_comb begin
        stage_nxt = stage;
        if (SCLR) begin
            stage_nxt = LINE_INIT;
        end else if (CE) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                stage_nxt[i] = stage[i-1];
            end
            stage_nxt[0] = D;
        end
    end

    generate
        if (NEG_EDGE == FALL) begin : g_fall
            // Stage registers on falling clock.
            always_ff @(negedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    stage <= LINE_INIT;
                end else begin
                    stage <= stage_nxt;
                end
            end
        end else begin : g_rise
            // Stage registers on rising clock.
            always_ff @(posedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    stage <= LINE_INIT;
                end else begin
                    stage <= stage_nxt;
                end
            end
        end
    endgenerate

    // Clamp out-of-range taps to the last stage.
    always_comb begin
        tap_c = TAP;
        if (int'(TAP) >= DEPTH) begin
            tap_c = AW'(DEPTH - 1);
        end
    end

    generate
        if (DEPTH == 1) begin : g_single
            assign Q = stage[0];
        end else begin : g_multi
            assign Q = stage[tap_c];
        end
    endgenerate

    dff_fill_ctr #(
        .DEPTH    (DEPTH),
        .NEG_EDGE (NEG_EDGE)
    ) u_fill (
        .CLK    (CLK),
        .RESETN (RESETN),
        .INC    (shift_en),
        .CLR    (SCLR),
        .count  (FILL)
    );

    assign PRIMED = (FILL > {1'b0, tap_c});

endmodule

// File: tb/tb_dff_delay_line.sv
// Scoreboard bench for dff_delay_line across
// several parameter sets sharing one stimulus bus.
module tb_dff_delay_line;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ce = 1'b0;
    logic       sclr = 1'b0;
    logic [7:0] d = 8'h00;
    logic [2:0] tap3 = 3'd0;
    logic       strobe = 1'b0;

    logic [7:0] q0, q1, q2, q3, q4;
    logic [2:0] f0, f1, f2;
    logic [3:0] f3;
    logic [1:0] f4;
    logic       p0, p1, p2, p3, p4;

    int checks = 0;
    int errors = 0;

    int     e_id [$];
    int     e_q  [$];
    int     e_f  [$];
    int     e_p  [$];
    string  e_nm [$];

    always #5 clk = ~clk;

    dff_delay_line #(.WIDTH(8), .DEPTH(4)) u0 (
        .CLK(clk), .RESETN(resetn), .CE(ce), .SCLR(sclr),
        .D(d), .TAP(tap3[1:0]), .Q(q0), .FILL(f0), .PRIMED(p0)
    );

    dff_delay_line #(.WIDTH(8), .DEPTH(4), .INIT(8'hC3)) u1 (
        .CLK(clk), .RESETN(resetn), .CE(ce), .SCLR(sclr),
        .D(d), .TAP(tap3[1:0]), .Q(q1), .FILL(f1), .PRIMED(p1)
    );

    dff_delay_line #(.WIDTH(8), .DEPTH(4), .NEG_EDGE(1'b1)) u2 (
        .CLK(clk), .RESETN(resetn), .CE(ce), .SCLR(sclr),
        .D(d), .TAP(tap3[1:0]), .Q(q2), .FILL(f2), .PRIMED(p2)
    );

    dff_delay_line #(.WIDTH(8), .DEPTH(5)) u3 (
        .CLK(clk), .RESETN(resetn), .CE(ce), .SCLR(sclr),
        .D(d), .TAP(tap3), .Q(q3), .FILL(f3), .PRIMED(p3)
    );

    dff_delay_line #(.WIDTH(8), .DEPTH(1)) u4 (
        .CLK(clk), .RESETN(resetn), .CE(ce), .SCLR(sclr),
        .D(d), .TAP(tap3[0]), .Q(q4), .FILL(f4), .PRIMED(p4)
    );

    task automatic expect_out(input string nm, input int id,
                              input int eq, input int ef,
                              input int ep);
        e_nm.push_back(nm);
        e_id.push_back(id);
        e_q.push_back(eq);
        e_f.push_back(ef);
        e_p.push_back(ep);
    endtask

    task automatic flush();
        #1 strobe = 1'b1;
        #1 strobe = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 resetn = 1'b0;
        #2 resetn = 1'b1;
    endtask

    // Monitor: pop expectations and compare on each strobe.
    initial begin
        int id, aq, af, ap;
        string nm;
        forever begin
            @(posedge strobe);
            while (e_id.size() > 0) begin
                id = e_id.pop_front();
                nm = e_nm.pop_front();
                case (id)
                    0: begin aq = q0; af = f0; ap = p0; end
                    1: begin aq = q1; af = f1; ap = p1; end
                    2: begin aq = q2; af = f2; ap = p2; end
                    3: begin aq = q3; af = f3; ap = p3; end
                    default: begin aq = q4; af = f4; ap = p4; end
                endcase
                checks++;
                if (aq != e_q[0] || af != e_f[0] || ap != e_p[0]) begin
                    errors++;
                    $display("FAIL %s: got q=%02h fill=%0d primed=%0d want q=%02h fill=%0d primed=%0d",
                             nm, aq, af, ap, e_q[0], e_f[0], e_p[0]);
                end
                void'(e_q.pop_front());
                void'(e_f.pop_front());
                void'(e_p.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Power-up / reset state.
        do_reset();
        tap3 = 3'd3;
        expect_out("rst_main", 0, 8'h00, 0, 0);
        expect_out("rst_init", 1, 8'hC3, 0, 0);
        flush();

        // Fill the line 11,22,33,44 with TAP=3.
        ce = 1'b1;
        d = 8'h11; step();
        d = 8'h22; step();
        d = 8'h33; step();
        expect_out("edge3", 0, 8'h00, 3, 0);
        flush();
        d = 8'h44; step();
        expect_out("edge4", 0, 8'h11, 4, 1);
        flush();
        tap3 = 3'd0;
        expect_out("tap0", 0, 8'h44, 4, 1);
        flush();
        d = 8'h55; step();
        tap3 = 3'd3;
        expect_out("sat4", 0, 8'h22, 4, 1);
        flush();

        // Clock-enable gaps.
        do_reset();
        tap3 = 3'd1;
        ce = 1'b1; d = 8'hA5; step();
        ce = 1'b0; d = 8'hFF; step();
        ce = 1'b1; d = 8'h5A; step();
        ce = 1'b0;
        expect_out("ce_tap1", 0, 8'hA5, 2, 1);
        flush();
        tap3 = 3'd0;
        expect_out("ce_tap0", 0, 8'h5A, 2, 1);
        flush();
        tap3 = 3'd2;
        expect_out("ce_tap2", 0, 8'h00, 2, 0);
        flush();

        // Full line then sync clear with CE high.
        do_reset();
        ce = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            d = 8'(i);
            step();
        end
        tap3 = 3'd3;
        expect_out("full", 0, 8'h01, 4, 1);
        flush();
        sclr = 1'b1; d = 8'h77; step();
        sclr = 1'b0; ce = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tap3 = 3'(t);
            expect_out("sclr", 0, 8'h00, 0, 0);
            flush();
        end

        // Async reset between edges after two shifts.
        do_reset();
        ce = 1'b1;
        d = 8'h12; step();
        d = 8'h34; step();
        ce = 1'b0;
        tap3 = 3'd1;
        expect_out("pre_rst", 0, 8'h12, 2, 1);
        expect_out("pre_rst_c3", 1, 8'h12, 2, 1);
        flush();
        #1 resetn = 1'b0;
        expect_out("mid_rst", 0, 8'h00, 0, 0);
        expect_out("mid_rst_c3", 1, 8'hC3, 0, 0);
        flush();
        resetn = 1'b1;
        ce = 1'b1; d = 8'h9A; step();
        ce = 1'b0;
        expect_out("post_rst", 0, 8'h00, 1, 0);
        expect_out("post_rst_c3", 1, 8'hC3, 1, 0);
        flush();
        tap3 = 3'd0;
        expect_out("post_rst_t0", 0, 8'h9A, 1, 1);
        flush();

        // Falling-edge variant.
        ce = 1'b0;
        do_reset();
        tap3 = 3'd0;
        @(negedge clk);
        #1 ce = 1'b1; d = 8'h3C;
        step();
        expect_out("neg_rise", 2, 8'h00, 0, 0);
        flush();
        @(negedge clk);
        #1;
        expect_out("neg_fall", 2, 8'h3C, 1, 1);
        flush();
        ce = 1'b0; d = 8'h00;
        step();
        expect_out("neg_hold", 2, 8'h3C, 1, 1);
        flush();

        // DEPTH=5 with out-of-range tap.
        do_reset();
        tap3 = 3'd7;
        ce = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            d = 8'(i);
            step();
        end
        expect_out("d5_fill4", 3, 8'h00, 4, 0);
        flush();
        d = 8'h05; step();
        expect_out("d5_fill5", 3, 8'h01, 5, 1);
        flush();
        d = 8'h06; step();
        expect_out("d5_sat", 3, 8'h02, 5, 1);
        flush();

        // DEPTH=1 saturation.
        ce = 1'b0;
        do_reset();
        expect_out("d1_rst", 4, 8'h00, 0, 0);
        flush();
        ce = 1'b1;
        d = 8'h01; step();
        expect_out("d1_first", 4, 8'h01, 1, 1);
        flush();
        for (int i = 2; i <= 10; i++) begin
            d = 8'(i);
            step();
        end
        ce = 1'b0;
        expect_out("d1_ten", 4, 8'h0A, 1, 1);
        flush();

        #5;
        if (e_id.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending want 0", e_id.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
